// File: rtl/seq_det_pkg.sv
// Shared definitions for the arbitrated serial pattern detector:
// FSM encoding, default sizing and the width helper.
package seq_det_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_PAT_W     = 4;
   localparam int DEF_BURST_LEN = 8;

   // Bits needed to hold values 0..n-1; never returns less than 1.
   function automatic int clog2_w(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant,
// wrapping, returned as one-hot plus index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] gnt_oh,
   output logic [ID_W-1:0]    gnt_idx,
   output logic               gnt_valid
);

   function automatic int wrap_idx(input int base, input int off);
      int s;
      s = base + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return s;
   endfunction

   int cand;

   // Offsets start at 1 so the previous winner is considered last.
   always_comb begin
      gnt_oh    = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = wrap_idx(int'(last_grant), i);
         if (!gnt_valid && req[cand]) begin
            gnt_valid    = 1'b1;
            gnt_idx      = ID_W'(cand);
            gnt_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_det_arbiter.sv
// One programmable serial pattern detector shared by NUM_REQ sources; each
// grant samples a fixed burst of BURST_LEN bits from the winning source.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for any req; grant, latch cfg and clear on the edge
//   ST_RUN  | shifting din of granted source, BURST_LEN edges
//   ST_DONE | one cycle: burst_done pulse, det_cnt valid, last_grant moves
module seq_det_arbiter
   import seq_det_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int PAT_W     = DEF_PAT_W,
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int ID_W      = clog2_w(NUM_REQ),
   parameter int CNT_W     = clog2_w(BURST_LEN + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] din,
   input  logic [PAT_W-1:0]   cfg_pattern,
   input  logic               cfg_overlap,
   output logic [NUM_REQ-1:0] gnt,
   output logic               busy,
   output logic               det_o,
   output logic [ID_W-1:0]    det_id,
   output logic               burst_done,
   output logic [CNT_W-1:0]   det_cnt
);

   localparam int FILL_W = clog2_w(PAT_W + 1);

   state_t             state_q;
   state_t             state_d;
   logic [ID_W-1:0]    last_grant_q;
   logic [NUM_REQ-1:0] arb_oh;
   logic [ID_W-1:0]    arb_idx;
   logic               arb_valid;
   logic [PAT_W-1:0]   pat_q;
   logic               ovl_q;
   logic [PAT_W-1:0]   shift_q;
   logic [PAT_W-1:0]   shift_next;
   logic [FILL_W-1:0]  fill_q;
   logic [FILL_W-1:0]  fill_next;
   logic [CNT_W-1:0]   bits_left_q;
   logic [CNT_W-1:0]   mcnt_q;
   logic [CNT_W-1:0]   mcnt_next;
   logic               match;
   logic               last_bit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req        (req),
      .last_grant (last_grant_q),
      .gnt_oh     (arb_oh),
      .gnt_idx    (arb_idx),
      .gnt_valid  (arb_valid)
   );

   // det_id doubles as the mux select for the granted stream.
   always_comb begin
      shift_next = {shift_q[PAT_W-2:0], din[det_id]};
      fill_next  = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
      match      = (state_q == ST_RUN) && (fill_next == FILL_W'(PAT_W)) &&
                   (shift_next == pat_q);
      mcnt_next  = mcnt_q + CNT_W'(match);
      last_bit   = (state_q == ST_RUN) && (bits_left_q == CNT_W'(1));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (arb_valid) state_d = ST_RUN;
         ST_RUN:  if (last_bit)  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gnt          <= '0;
         det_o        <= 1'b0;
         det_id       <= '0;
         burst_done   <= 1'b0;
         det_cnt      <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         pat_q        <= '0;
         ovl_q        <= 1'b0;
         shift_q      <= '0;
         fill_q       <= '0;
         bits_left_q  <= '0;
         mcnt_q       <= '0;
      end else begin
         det_o      <= 1'b0;
         burst_done <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  gnt         <= arb_oh;
                  det_id      <= arb_idx;
                  pat_q       <= cfg_pattern;
                  ovl_q       <= cfg_overlap;
                  shift_q     <= '0;
                  fill_q      <= '0;
                  mcnt_q      <= '0;
                  bits_left_q <= CNT_W'(BURST_LEN);
               end
            end
            ST_RUN: begin
               shift_q     <= shift_next;
               // Non-overlapping mode needs a full fresh window after a hit.
               fill_q      <= (match && !ovl_q) ? '0 : fill_next;
               bits_left_q <= bits_left_q - 1'b1;
               det_o       <= match;
               mcnt_q      <= mcnt_next;
               if (last_bit) begin
                  gnt        <= '0;
                  burst_done <= 1'b1;
                  det_cnt    <= mcnt_next;
               end
            end
            ST_DONE: last_grant_q <= det_id;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scoreboard bench for seq_det_arbiter: drivers queue expected burst records,
// a negedge monitor assembles each observed burst and compares on burst_done.
module tb_seq_det_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] din = '0;
   logic [3:0] cfg_pattern = '0;
   logic       cfg_overlap = 1'b0;
   logic [3:0] gnt;
   logic       busy;
   logic       det_o;
   logic [1:0] det_id;
   logic       burst_done;
   logic [3:0] det_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int gnt;
      int id;
      int cnt;
      int mask;
      int gap;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   seq_det_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .din         (din),
      .cfg_pattern (cfg_pattern),
      .cfg_overlap (cfg_overlap),
      .gnt         (gnt),
      .busy        (busy),
      .det_o       (det_o),
      .det_id      (det_id),
      .burst_done  (burst_done),
      .det_cnt     (det_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: tracks each grant window, records det_o positions by bit index.
   bit       in_run = 1'b0;
   logic [3:0] cur_gnt = '0;
   logic [3:0] prev_gnt = '0;
   logic [8:0] mask = '0;
   int       c = 0;
   int       gcyc = 0;
   int       gap = 0;
   int       last_rise = -1;
   exp_t     e;

   always @(negedge clock) begin
      if (!reset) begin
         in_run    = 1'b0;
         prev_gnt  = '0;
         last_rise = -1;
      end else begin
         if (gnt != 0 && prev_gnt == 0) begin
            in_run    = 1'b1;
            c         = 0;
            mask      = '0;
            cur_gnt   = gnt;
            gcyc      = 0;
            gap       = (last_rise < 0) ? 0 : cyc - last_rise;
            last_rise = cyc;
         end
         if (det_o && !in_run) chk("det_o_outside_burst", 1, 0);
         if (in_run) begin
            if (gnt != 0) begin
               gcyc++;
               if (gnt != cur_gnt) chk("gnt_stable", int'(gnt), int'(cur_gnt));
            end
            if (det_o && c <= 8) mask[c] = 1'b1;
            if (burst_done) begin
               if (sb.size() == 0) begin
                  chk("unexpected_burst_done", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("gnt", int'(cur_gnt), e.gnt);
                  chk("det_id", int'(det_id), e.id);
                  chk("det_cnt", int'(det_cnt), e.cnt);
                  chk("det_mask", int'(mask), e.mask);
                  chk("gnt_cycles", gcyc, 8);
                  chk("done_pos", c, 8);
                  chk("busy_in_done", int'(busy), 1);
                  if (e.gap != 0) chk("grant_period", gap, e.gap);
               end
               in_run = 1'b0;
            end
            c++;
         end else if (burst_done) begin
            chk("burst_done_no_grant", 1, 0);
         end
         prev_gnt = gnt;
      end
   end

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clock);
         if (gnt != 0) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_gnt timeout actual gnt=%b required nonzero", gnt);
      end
   endtask

   // mode 0: plain burst; 1: drop req and flip cfg after bit 3; 2: reset after bit 3
   task automatic run_burst(input logic [3:0] rq, input logic [3:0] pat, input bit ovl,
                            input int src, input logic [7:0] stream, input int mode);
      bit ok;
      logic b;
      req = rq;
      cfg_pattern = pat;
      cfg_overlap = ovl;
      wait_gnt(ok);
      if (!ok) return;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clock);
         b = stream[7-i];
         din = b ? 4'h0 : 4'hF;
         din[src] = b;
         if (i == 0 && mode != 1) req = '0;
         if (i == 3 && mode == 1) begin
            req = '0;
            cfg_pattern = ~pat;
            cfg_overlap = ~ovl;
         end
         if (i == 3 && mode == 2) begin
            reset = 1'b0;
            #1;
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_det_o", int'(det_o), 0);
            chk("rst_burst_done", int'(burst_done), 0);
            return;
         end
      end
      repeat (3) @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      bit ok;
      repeat (2) @(negedge clock);
      chk("reset_gnt", int'(gnt), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_det_o", int'(det_o), 0);
      chk("reset_burst_done", int'(burst_done), 0);
      chk("reset_det_id", int'(det_id), 0);
      chk("reset_det_cnt", int'(det_cnt), 0);
      reset = 1'b1;
      @(negedge clock);

      // Round robin with req held: one grant per 10 cycles, source 0 first.
      sb.push_back('{gnt: 1, id: 0, cnt: 0, mask: 0, gap: 0});
      sb.push_back('{gnt: 2, id: 1, cnt: 0, mask: 0, gap: 10});
      sb.push_back('{gnt: 4, id: 2, cnt: 0, mask: 0, gap: 10});
      sb.push_back('{gnt: 8, id: 3, cnt: 0, mask: 0, gap: 10});
      sb.push_back('{gnt: 1, id: 0, cnt: 0, mask: 0, gap: 10});
      req = 4'hF;
      cfg_pattern = 4'b1011;
      cfg_overlap = 1'b1;
      din = '0;
      for (int n = 0; n < 5; n++) begin
         wait_gnt(ok);
         if (n == 4) req = '0;
         for (int j = 0; j < 12 && gnt != 0; j++) @(negedge clock);
      end
      repeat (3) @(negedge clock);

      // Overlapping 1011 over 1,0,1,1,0,1,1,0: hits after bits 4 and 7.
      sb.push_back('{gnt: 1, id: 0, cnt: 2, mask: 'h090, gap: 0});
      run_burst(4'b0001, 4'b1011, 1'b1, 0, 8'b1011_0110, 0);

      // Same stream non-overlapping: only bit 4.
      sb.push_back('{gnt: 1, id: 0, cnt: 1, mask: 'h010, gap: 0});
      run_burst(4'b0001, 4'b1011, 1'b0, 0, 8'b1011_0110, 0);

      // All ones against 1111: hits after bits 4..8, last one during burst_done.
      sb.push_back('{gnt: 4, id: 2, cnt: 5, mask: 'h1F0, gap: 0});
      run_burst(4'b0100, 4'b1111, 1'b1, 2, 8'hFF, 0);

      // Mid-burst req drop and cfg change are ignored.
      sb.push_back('{gnt: 8, id: 3, cnt: 2, mask: 'h090, gap: 0});
      run_burst(4'b1000, 4'b1011, 1'b1, 3, 8'b1011_0110, 1);

      // Reset after bit 3 aborts without burst_done.
      run_burst(4'b0001, 4'b1111, 1'b1, 0, 8'hFF, 2);
      repeat (2) @(negedge clock);
      chk("rst_det_id_held", int'(det_id), 0);
      chk("rst_det_cnt_held", int'(det_cnt), 0);
      reset = 1'b1;

      // After reset, source 1 wins from req=0110.
      sb.push_back('{gnt: 2, id: 1, cnt: 2, mask: 'h110, gap: 0});
      run_burst(4'b0110, 4'b0111, 1'b0, 1, 8'b0111_0111, 0);

      repeat (4) @(negedge clock);
      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
